// File: rtl/cdec_datapath_pkg.sv
// Shared CDEC control-code constants: X-bus source/destination, ALU ops, flag positions.
package cdec_datapath_pkg;

  localparam int unsigned DW    = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned FLG_W = 3;

  localparam int unsigned FLG_S  = 2;
  localparam int unsigned FLG_Z  = 1;
  localparam int unsigned FLG_CY = 0;

  localparam logic [SEL_W-1:0] xsrc_A  = 3'd0;
  localparam logic [SEL_W-1:0] xsrc_B  = 3'd1;
  localparam logic [SEL_W-1:0] xsrc_C  = 3'd2;
  localparam logic [SEL_W-1:0] xsrc_PC = 3'd3;
  localparam logic [SEL_W-1:0] xsrc_R  = 3'd4;
  localparam logic [SEL_W-1:0] xsrc_RD = 3'd5;

  localparam logic [SEL_W-1:0] xdst_A   = 3'd0;
  localparam logic [SEL_W-1:0] xdst_B   = 3'd1;
  localparam logic [SEL_W-1:0] xdst_C   = 3'd2;
  localparam logic [SEL_W-1:0] xdst_T   = 3'd3;
  localparam logic [SEL_W-1:0] xdst_PC  = 3'd4;
  localparam logic [SEL_W-1:0] xdst_MAR = 3'd5;
  localparam logic [SEL_W-1:0] xdst_I   = 3'd6;
  localparam logic [SEL_W-1:0] xdst_WDR = 3'd7;

  localparam logic [OP_W-1:0] aluop_ZERO = 4'd0;
  localparam logic [OP_W-1:0] aluop_INC  = 4'd1;
  localparam logic [OP_W-1:0] aluop_DEC  = 4'd2;
  localparam logic [OP_W-1:0] aluop_NOT  = 4'd3;
  localparam logic [OP_W-1:0] aluop_ADD  = 4'd4;
  localparam logic [OP_W-1:0] aluop_ADC  = 4'd5;
  localparam logic [OP_W-1:0] aluop_SUB  = 4'd6;
  localparam logic [OP_W-1:0] aluop_SBB  = 4'd7;
  localparam logic [OP_W-1:0] aluop_AND  = 4'd8;
  localparam logic [OP_W-1:0] aluop_OR   = 4'd9;
  localparam logic [OP_W-1:0] aluop_EOR  = 4'd10;

endpackage

// File: rtl/cdec_alu.sv
// CDEC ALU: combinational 8-bit result plus S/Z/Cy from operand X, second operand T and carry-in.
module cdec_alu
  import cdec_datapath_pkg::*;
(
  input  logic [DW-1:0]   x,
  input  logic [DW-1:0]   t,
  input  logic            cy_in,
  input  logic [OP_W-1:0] aluop,
  output logic [DW-1:0]   result,
  output logic            s,
  output logic            z,
  output logic            cy
);

  logic [DW:0] wide;

  // Bit 8 of the 9-bit sum/difference is carry for adds and borrow for subtracts.
  always_comb begin
    wide = '0;
    case (aluop)
      aluop_INC: wide = {1'b0, x} + 9'd1;
      aluop_DEC: wide = {1'b0, x} - 9'd1;
      aluop_NOT: wide = {1'b0, ~x};
      aluop_ADD: wide = {1'b0, x} + {1'b0, t};
      aluop_ADC: wide = {1'b0, x} + {1'b0, t} + 9'(cy_in);
      aluop_SUB: wide = {1'b0, x} - {1'b0, t};
      aluop_SBB: wide = {1'b0, x} - {1'b0, t} - 9'(cy_in);
      aluop_AND: wide = {1'b0, x & t};
      aluop_OR:  wide = {1'b0, x | t};
      aluop_EOR: wide = {1'b0, x ^ t};
      default:   wide = '0;
    endcase
    result = wide[DW-1:0];
    s      = wide[DW-1];
    z      = (wide[DW-1:0] == 8'h00);
    cy     = wide[DW];
  end

endmodule

// File: rtl/cdec_datapath.sv
// CDEC 8-bit datapath: register file, X-bus mux, ALU/flags and memory port.
// Optional CDEC_MONITOR_HALT_EN adds mon_halt, which freezes all state and blocks writes.
module cdec_datapath
  import cdec_datapath_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [SEL_W-1:0]  xsrc,
  input  logic [SEL_W-1:0]  xdst,
  input  logic [OP_W-1:0]   aluop,
  input  logic              Rwe,
  input  logic              FLGwe,
  input  logic              MEMwe,
  input  logic [DW-1:0]     mem_rdata,
  output logic [DW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic              mem_we,
  output logic [DW-1:0]     I,
  output logic [FLG_W-1:0]  SZCy
`ifdef CDEC_MONITOR_HALT_EN
  ,
  input  logic              mon_halt
`endif
);

  logic [DW-1:0]    a_q, b_q, c_q, t_q, r_q, pc_q, mar_q, i_q, wdr_q;
  logic [DW-1:0]    a_d, b_d, c_d, t_d, r_d, pc_d, mar_d, i_d, wdr_d;
  logic [FLG_W-1:0] flg_q, flg_d;
  logic [DW-1:0]    x_bus_c;
  logic [DW-1:0]    alu_res;
  logic             alu_s, alu_z, alu_cy;
  logic             run_c;

`ifdef CDEC_MONITOR_HALT_EN
  assign run_c = ~mon_halt;
`else
  assign run_c = 1'b1;
`endif

  always_comb begin
    case (xsrc)
      xsrc_A:  x_bus_c = a_q;
      xsrc_B:  x_bus_c = b_q;
      xsrc_C:  x_bus_c = c_q;
      xsrc_PC: x_bus_c = pc_q;
      xsrc_R:  x_bus_c = r_q;
      xsrc_RD: x_bus_c = mem_rdata;
      default: x_bus_c = 8'h00;
    endcase
  end

  cdec_alu u_alu (
    .x      (x_bus_c),
    .t      (t_q),
    .cy_in  (flg_q[FLG_CY]),
    .aluop  (aluop),
    .result (alu_res),
    .s      (alu_s),
    .z      (alu_z),
    .cy     (alu_cy)
  );

  // Bus destination, R and flags update independently in the same edge.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    t_d   = t_q;
    r_d   = r_q;
    pc_d  = pc_q;
    mar_d = mar_q;
    i_d   = i_q;
    wdr_d = wdr_q;
    flg_d = flg_q;
    if (run_c) begin
      case (xdst)
        xdst_A:   a_d   = x_bus_c;
        xdst_B:   b_d   = x_bus_c;
        xdst_C:   c_d   = x_bus_c;
        xdst_T:   t_d   = x_bus_c;
        xdst_PC:  pc_d  = x_bus_c;
        xdst_MAR: mar_d = x_bus_c;
        xdst_I:   i_d   = x_bus_c;
        default:  wdr_d = x_bus_c;
      endcase
      if (Rwe) begin
        r_d = alu_res;
      end
      if (FLGwe) begin
        flg_d[FLG_S]  = alu_s;
        flg_d[FLG_Z]  = alu_z;
        flg_d[FLG_CY] = alu_cy;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      t_q   <= '0;
      r_q   <= '0;
      pc_q  <= '0;
      mar_q <= '0;
      i_q   <= '0;
      wdr_q <= '0;
      flg_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      t_q   <= t_d;
      r_q   <= r_d;
      pc_q  <= pc_d;
      mar_q <= mar_d;
      i_q   <= i_d;
      wdr_q <= wdr_d;
      flg_q <= flg_d;
    end
  end

  assign mem_addr  = mar_q;
  assign mem_wdata = wdr_q;
  assign mem_we    = MEMwe & run_c;
  assign I         = i_q;
  assign SZCy      = flg_q;

endmodule

// File: tb/tb_cdec_datapath.sv
// Bench for cdec_datapath: directed vector table, hand sequences and a randomized run against a reference model.
module tb_cdec_datapath;
  import cdec_datapath_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] xsrc, xdst;
  logic [3:0] aluop;
  logic       Rwe, FLGwe, MEMwe;
  logic [7:0] mem_rdata;
  logic [7:0] mem_addr, mem_wdata, I;
  logic       mem_we;
  logic [2:0] SZCy;
`ifdef CDEC_MONITOR_HALT_EN
  logic       mon_halt = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cdec_datapath dut (
    .clk       (clk),
    .reset     (reset),
    .xsrc      (xsrc),
    .xdst      (xdst),
    .aluop     (aluop),
    .Rwe       (Rwe),
    .FLGwe     (FLGwe),
    .MEMwe     (MEMwe),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .I         (I),
    .SZCy      (SZCy)
`ifdef CDEC_MONITOR_HALT_EN
    ,
    .mon_halt  (mon_halt)
`endif
  );

  typedef struct {
    logic [2:0] s, d;
    logic [3:0] op;
    logic       rwe, fwe, mwe;
    logic [7:0] rd;
    logic [7:0] e_addr, e_wdata, e_i;
    logic [2:0] e_f;
  } vec_t;

  vec_t tbl[$];

  // Reference state for the randomized run.
  int m_a, m_b, m_c, m_t, m_r, m_pc, m_mar, m_i, m_wdr, m_s, m_z, m_cy;

  function automatic vec_t v(input logic [2:0] s, d, input logic [3:0] op,
                             input logic rwe, fwe, mwe, input logic [7:0] rd,
                             input logic [7:0] ea, ew, ei, input logic [2:0] ef);
    vec_t r;
    r.s = s; r.d = d; r.op = op; r.rwe = rwe; r.fwe = fwe; r.mwe = mwe; r.rd = rd;
    r.e_addr = ea; r.e_wdata = ew; r.e_i = ei; r.e_f = ef;
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] s, d, input logic [3:0] op,
                       input logic rwe, fwe, mwe, input logic [7:0] rd);
    xsrc = s; xdst = d; aluop = op; Rwe = rwe; FLGwe = fwe; MEMwe = mwe; mem_rdata = rd;
  endtask

  task automatic step_nc(input logic [2:0] s, d, input logic [3:0] op,
                         input logic rwe, fwe, mwe, input logic [7:0] rd);
    drive(s, d, op, rwe, fwe, mwe, rd);
    @(posedge clk); #1;
  endtask

  task automatic check_outs(input string tag, input logic [7:0] ea, ew, ei, input logic [2:0] ef);
    chk({tag, " mem_addr"}, mem_addr, ea);
    chk({tag, " mem_wdata"}, mem_wdata, ew);
    chk({tag, " I"}, I, ei);
    chk({tag, " SZCy"}, 8'(SZCy), 8'(ef));
  endtask

  task automatic apply(input vec_t r, input string tag);
    drive(r.s, r.d, r.op, r.rwe, r.fwe, r.mwe, r.rd);
    #1;
    chk({tag, " mem_we"}, 8'(mem_we), 8'(r.mwe));
    @(posedge clk); #1;
    check_outs(tag, r.e_addr, r.e_wdata, r.e_i, r.e_f);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    drive(xsrc_PC, xdst_PC, aluop_ZERO, 1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    m_a = 0; m_b = 0; m_c = 0; m_t = 0; m_r = 0; m_pc = 0;
    m_mar = 0; m_i = 0; m_wdr = 0; m_s = 0; m_z = 0; m_cy = 0;
  endtask

  // ALU from the arithmetic definitions: carry is overflow past 255, borrow is going negative.
  function automatic void ref_alu(input int op, x, t, cyi, output int res, output int cyo);
    int val;
    case (op)
      1: val = x + 1;
      2: val = x - 1;
      3: val = 255 - x;
      4: val = x + t;
      5: val = x + t + cyi;
      6: val = x - t;
      7: val = x - t - cyi;
      8: val = x & t;
      9: val = x | t;
      10: val = x ^ t;
      default: val = 0;
    endcase
    res = ((val % 256) + 256) % 256;
    if (op == 1 || op == 4 || op == 5) cyo = (val > 255) ? 1 : 0;
    else if (op == 2 || op == 6 || op == 7) cyo = (val < 0) ? 1 : 0;
    else cyo = 0;
  endfunction

  task automatic model_step(input int s, d, op, rwe, fwe, rd);
    int x, res, c;
    case (s)
      0: x = m_a;
      1: x = m_b;
      2: x = m_c;
      3: x = m_pc;
      4: x = m_r;
      5: x = rd;
      default: x = 0;
    endcase
    ref_alu(op, x, m_t, m_cy, res, c);
    case (d)
      0: m_a = x;
      1: m_b = x;
      2: m_c = x;
      3: m_t = x;
      4: m_pc = x;
      5: m_mar = x;
      6: m_i = x;
      default: m_wdr = x;
    endcase
    if (rwe != 0) m_r = res;
    if (fwe != 0) begin
      m_s = (res >= 128) ? 1 : 0;
      m_z = (res == 0) ? 1 : 0;
      m_cy = c;
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(xsrc_PC, xdst_PC, aluop_ZERO, 1'b0, 1'b0, 1'b0, 8'h5A);
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 8'h00, 8'h00, 8'h00, 3'b000);
    chk("reset mem_we", 8'(mem_we), 8'h00);
    reset = 1'b0;

    // Fetch, ADD/SBB/SUB flag cases, store, unused xsrc, PC wrap.
    tbl.push_back(v(xsrc_PC, xdst_MAR, aluop_INC, 1, 0, 0, 8'h5A, 8'h00, 8'h00, 8'h00, 3'b000));
    tbl.push_back(v(xsrc_R, xdst_PC, aluop_ZERO, 0, 0, 0, 8'h5A, 8'h00, 8'h00, 8'h00, 3'b000));
    tbl.push_back(v(xsrc_RD, xdst_I, aluop_ZERO, 0, 0, 0, 8'h5A, 8'h00, 8'h00, 8'h5A, 3'b000));
    tbl.push_back(v(xsrc_PC, xdst_WDR, aluop_ZERO, 0, 0, 0, 8'h00, 8'h00, 8'h01, 8'h5A, 3'b000));
    tbl.push_back(v(xsrc_RD, xdst_T, aluop_ZERO, 0, 0, 0, 8'h01, 8'h00, 8'h01, 8'h5A, 3'b000));
    tbl.push_back(v(xsrc_RD, xdst_A, aluop_ZERO, 0, 0, 0, 8'hFF, 8'h00, 8'h01, 8'h5A, 3'b000));
    tbl.push_back(v(xsrc_A, xdst_A, aluop_ADD, 1, 1, 0, 8'h00, 8'h00, 8'h01, 8'h5A, 3'b011));
    tbl.push_back(v(xsrc_R, xdst_A, aluop_ZERO, 0, 0, 0, 8'h00, 8'h00, 8'h01, 8'h5A, 3'b011));
    tbl.push_back(v(xsrc_A, xdst_WDR, aluop_ZERO, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h5A, 3'b011));
    tbl.push_back(v(xsrc_RD, xdst_A, aluop_ZERO, 0, 0, 0, 8'h10, 8'h00, 8'h00, 8'h5A, 3'b011));
    tbl.push_back(v(xsrc_RD, xdst_T, aluop_ZERO, 0, 0, 0, 8'h05, 8'h00, 8'h00, 8'h5A, 3'b011));
    tbl.push_back(v(xsrc_A, xdst_A, aluop_SBB, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h5A, 3'b000));
    tbl.push_back(v(xsrc_R, xdst_WDR, aluop_ZERO, 0, 0, 0, 8'h00, 8'h00, 8'h0A, 8'h5A, 3'b000));
    tbl.push_back(v(xsrc_RD, xdst_A, aluop_ZERO, 0, 0, 0, 8'h00, 8'h00, 8'h0A, 8'h5A, 3'b000));
    tbl.push_back(v(xsrc_RD, xdst_T, aluop_ZERO, 0, 0, 0, 8'h01, 8'h00, 8'h0A, 8'h5A, 3'b000));
    tbl.push_back(v(xsrc_A, xdst_A, aluop_SUB, 1, 1, 0, 8'h00, 8'h00, 8'h0A, 8'h5A, 3'b101));
    tbl.push_back(v(xsrc_R, xdst_WDR, aluop_ZERO, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 8'h5A, 3'b101));
    tbl.push_back(v(xsrc_RD, xdst_MAR, aluop_ZERO, 0, 0, 0, 8'h80, 8'h80, 8'hFF, 8'h5A, 3'b101));
    tbl.push_back(v(xsrc_RD, xdst_A, aluop_ZERO, 0, 0, 0, 8'h3C, 8'h80, 8'hFF, 8'h5A, 3'b101));
    tbl.push_back(v(xsrc_A, xdst_WDR, aluop_ZERO, 0, 0, 0, 8'h00, 8'h80, 8'h3C, 8'h5A, 3'b101));
    tbl.push_back(v(xsrc_PC, xdst_PC, aluop_ZERO, 0, 0, 1, 8'h00, 8'h80, 8'h3C, 8'h5A, 3'b101));
    tbl.push_back(v(3'd6, xdst_WDR, aluop_ZERO, 0, 0, 0, 8'hC3, 8'h80, 8'h00, 8'h5A, 3'b101));
    tbl.push_back(v(xsrc_RD, xdst_PC, aluop_ZERO, 0, 0, 0, 8'hFF, 8'h80, 8'h00, 8'h5A, 3'b101));
    tbl.push_back(v(xsrc_PC, xdst_MAR, aluop_INC, 1, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h5A, 3'b101));
    tbl.push_back(v(xsrc_R, xdst_PC, aluop_ZERO, 0, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h5A, 3'b101));
    tbl.push_back(v(xsrc_RD, xdst_WDR, aluop_ZERO, 0, 0, 0, 8'h77, 8'hFF, 8'h77, 8'h5A, 3'b101));
    tbl.push_back(v(xsrc_PC, xdst_WDR, aluop_ZERO, 0, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h5A, 3'b101));
    foreach (tbl[k]) apply(tbl[k], $sformatf("row%0d", k));

    // Randomized control words against the reference model.
    pulse_reset();
    for (int n = 0; n < 400; n++) begin
      logic [2:0] s, d;
      logic [3:0] op;
      logic rwe, fwe, mwe;
      logic [7:0] rd;
      s = 3'($urandom_range(0, 7));
      d = 3'($urandom_range(0, 7));
      op = 4'($urandom_range(0, 10));
      rwe = 1'($urandom_range(0, 1));
      fwe = 1'($urandom_range(0, 1));
      mwe = 1'($urandom_range(0, 1));
      rd = 8'($urandom_range(0, 255));
      drive(s, d, op, rwe, fwe, mwe, rd);
      #1;
      chk($sformatf("rnd%0d mem_we", n), 8'(mem_we), 8'(mwe));
      model_step(int'(s), int'(d), int'(op), int'(rwe), int'(fwe), int'(rd));
      @(posedge clk); #1;
      check_outs($sformatf("rnd%0d", n), 8'(m_mar), 8'(m_wdr), 8'(m_i),
                 {1'(m_s), 1'(m_z), 1'(m_cy)});
    end

    // Reset asserted in the middle of an ADC word that also requests a write.
    step_nc(xsrc_RD, xdst_MAR, aluop_ZERO, 0, 0, 0, 8'h11);
    step_nc(xsrc_RD, xdst_WDR, aluop_ZERO, 0, 0, 0, 8'h22);
    step_nc(xsrc_RD, xdst_I, aluop_ZERO, 0, 0, 0, 8'h33);
    step_nc(xsrc_RD, xdst_A, aluop_ZERO, 0, 0, 0, 8'hF0);
    step_nc(xsrc_RD, xdst_T, aluop_ZERO, 0, 0, 0, 8'h20);
    step_nc(xsrc_A, xdst_A, aluop_ADD, 1, 1, 0, 8'h00);
    check_outs("pre_reset", 8'h11, 8'h22, 8'h33, 3'b001);
    drive(xsrc_A, xdst_A, aluop_ADC, 1, 1, 1, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    MEMwe = 1'b0;
    #1;
    check_outs("mid_reset", 8'h00, 8'h00, 8'h00, 3'b000);
    chk("mid_reset mem_we", 8'(mem_we), 8'h00);
    @(posedge clk); #1;
    check_outs("held_reset", 8'h00, 8'h00, 8'h00, 3'b000);
    reset = 1'b0;
    apply(v(xsrc_A, xdst_WDR, aluop_ZERO, 0, 0, 0, 8'h99, 8'h00, 8'h00, 8'h00, 3'b000), "post_reset_A");

`ifdef CDEC_MONITOR_HALT_EN
    // Halt freezes INC A and blocks the write; release applies it on the next edge.
    step_nc(xsrc_RD, xdst_A, aluop_ZERO, 0, 0, 0, 8'hFF);
    mon_halt = 1'b1;
    drive(xsrc_A, xdst_A, aluop_INC, 1, 1, 1, 8'h00);
    #1;
    chk("halt mem_we", 8'(mem_we), 8'h00);
    @(posedge clk); #1;
    chk("halt SZCy", 8'(SZCy), 8'h00);
    mon_halt = 1'b0;
    apply(v(xsrc_A, xdst_WDR, aluop_ZERO, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 8'h00, 3'b000), "halt_A_kept");
    apply(v(xsrc_A, xdst_A, aluop_INC, 1, 1, 1, 8'h00, 8'h00, 8'hFF, 8'h00, 3'b011), "release_inc");
    apply(v(xsrc_R, xdst_WDR, aluop_ZERO, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 3'b011), "release_R");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
